// File: rtl/plastic_neuron_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// plastic_pkg
// Shared constants, types and helpers for the plastic-neuron blocks.
//   DATA_W / PROD_W     : operand and product widths of the shared datapath
//   DEFAULT_*           : default learning step and initial weight
//   sched_state_t       : scheduler FSM states
//   sat_add16()         : signed add evaluated one bit wider, then clamped
// -----------------------------------------------------------------------------
package plastic_pkg;

  localparam int DATA_W                = 16;
  localparam int PROD_W                = 32;
  localparam int DEFAULT_LEARNING_RATE = 10;
  localparam int DEFAULT_INIT_WEIGHT   = 1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  // The sum is formed at DATA_W+1 bits so it can never wrap before the
  // clamp compares it against the bounds.
  function automatic logic signed [DATA_W-1:0] sat_add16(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic signed [DATA_W-1:0] lo,
    input logic signed [DATA_W-1:0] hi
  );
    logic signed [DATA_W:0] sum;
    logic signed [DATA_W:0] lo_x;
    logic signed [DATA_W:0] hi_x;
    sum  = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    lo_x = {lo[DATA_W-1], lo};
    hi_x = {hi[DATA_W-1], hi};
    if (sum > hi_x) begin
      return hi;
    end else if (sum < lo_x) begin
      return lo;
    end
    return sum[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/plastic_neuron_scheduler_if.sv
// -----------------------------------------------------------------------------
// plastic_neuron_scheduler_if
// Request/response bundle between the front-ends and the scheduler.
//   req_valid/req_ready       : per-requester handshake (ready one-hot or zero)
//   req_neuron/input/error    : flattened per-requester payload, slice i = req i
//   req_learn, learn_freeze   : per-request plasticity enable, global inhibit
//   rsp_valid/rsp_ready       : response handshake
//   rsp_data/req_id/neuron    : tagged signed product
//   busy                      : scheduler not idle
// Modports: master = requester/consumer side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface plastic_neuron_scheduler_if
  import plastic_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NEUR_W  = 3
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*NEUR_W-1:0] req_neuron;
  logic [NUM_REQ*DATA_W-1:0] req_input;
  logic [NUM_REQ*DATA_W-1:0] req_error;
  logic [NUM_REQ-1:0]        req_learn;
  logic                      learn_freeze;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [PROD_W-1:0]         rsp_data;
  logic [ID_W-1:0]           rsp_req_id;
  logic [NEUR_W-1:0]         rsp_neuron;
  logic                      busy;

  modport master (
    output req_valid, req_neuron, req_input, req_error, req_learn,
           learn_freeze, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_req_id, rsp_neuron, busy
  );

  modport slave (
    input  req_valid, req_neuron, req_input, req_error, req_learn,
           learn_freeze, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_req_id, rsp_neuron, busy
  );

endinterface

// File: rtl/plastic_neuron_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first asserted req bit found when
// scanning upward from ptr, wrapping modulo N.
//   req       : request vector
//   ptr       : highest-priority index (owned by the caller)
//   grant     : one-hot grant, zero when no request
//   grant_idx : encoded grant index
//   grant_any : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  // Scan from the farthest offset down so the last hit written is the one
  // nearest to ptr.
  always_comb begin
    int k;
    k         = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int off = N - 1; off >= 0; off--) begin
      k = (int'(ptr) + off) % N;
      if (req[k]) begin
        grant     = '0;
        grant[k]  = 1'b1;
        grant_idx = IDX_W'(k);
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/plastic_neuron_scheduler.sv
// -----------------------------------------------------------------------------
// plastic_neuron_scheduler
// Shares one signed 16x16 multiplier plus Hebbian weight-update datapath
// among NUM_REQ requesters, over a bank of 2**NEUR_W neuron weights.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of plastic_neuron_scheduler_if (requests in,
//              tagged 32-bit response out, busy)
// Flow: IDLE (round-robin accept) -> EXEC (multiply with the pre-update
// weight, commit learning) -> RESP (hold response until rsp_ready).
// -----------------------------------------------------------------------------
module plastic_neuron_scheduler
  import plastic_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int NEUR_W        = 3,
  parameter int LEARNING_RATE = DEFAULT_LEARNING_RATE,
  parameter int INIT_WEIGHT   = DEFAULT_INIT_WEIGHT,
  parameter int W_MAX         = 32767,
  parameter int W_MIN         = -32768
) (
  input logic                         clk,
  input logic                         rst,
  plastic_neuron_scheduler_if.slave   bus
);

  localparam int ID_W     = $clog2(NUM_REQ);
  localparam int NUM_NEUR = 1 << NEUR_W;

  localparam logic signed [DATA_W-1:0] LR_POS = DATA_W'(LEARNING_RATE);
  localparam logic signed [DATA_W-1:0] LR_NEG = DATA_W'(-LEARNING_RATE);
  localparam logic signed [DATA_W-1:0] W_HI   = DATA_W'(W_MAX);
  localparam logic signed [DATA_W-1:0] W_LO   = DATA_W'(W_MIN);
  localparam logic signed [DATA_W-1:0] W_INIT = DATA_W'(INIT_WEIGHT);

  sched_state_t               state_q, state_d;
  logic [ID_W-1:0]            ptr_q, ptr_d;
  logic [ID_W-1:0]            cap_id_q, cap_id_d;
  logic [NEUR_W-1:0]          cap_neuron_q, cap_neuron_d;
  logic signed [DATA_W-1:0]   cap_input_q, cap_input_d;
  logic signed [DATA_W-1:0]   cap_error_q, cap_error_d;
  logic                       cap_learn_q, cap_learn_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic signed [PROD_W-1:0]   rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]            rsp_id_q, rsp_id_d;
  logic [NEUR_W-1:0]          rsp_neuron_q, rsp_neuron_d;
  logic signed [DATA_W-1:0]   weight_q [NUM_NEUR];
  logic signed [DATA_W-1:0]   weight_d [NUM_NEUR];

  logic [NUM_REQ-1:0]         grant;
  logic [ID_W-1:0]            grant_idx;
  logic                       grant_any;
  logic                       accept;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Ready is only ever offered to the arbitration winner, so a winner
  // existing in IDLE is the handshake.
  assign bus.req_ready = (state_q == IDLE) ? grant : '0;
  assign accept        = (state_q == IDLE) && grant_any;

  logic [NEUR_W-1:0]        win_neuron;
  logic signed [DATA_W-1:0] win_input;
  logic signed [DATA_W-1:0] win_error;

  assign win_neuron = bus.req_neuron[grant_idx*NEUR_W +: NEUR_W];
  assign win_input  = $signed(bus.req_input[grant_idx*DATA_W +: DATA_W]);
  assign win_error  = $signed(bus.req_error[grant_idx*DATA_W +: DATA_W]);

  // EXEC datapath: product uses the weight as it was before this update.
  logic signed [DATA_W-1:0] w_cur;
  logic signed [DATA_W-1:0] w_upd;
  logic signed [PROD_W-1:0] in_ext, w_ext, product;
  logic                     input_pos, error_pos, error_nz, learn_hit;

  assign w_cur   = weight_q[cap_neuron_q];
  assign in_ext  = {{(PROD_W-DATA_W){cap_input_q[DATA_W-1]}}, cap_input_q};
  assign w_ext   = {{(PROD_W-DATA_W){w_cur[DATA_W-1]}}, w_cur};
  assign product = in_ext * w_ext;

  // Sign tests by bit inspection keep the compares free of signedness traps.
  assign input_pos = !cap_input_q[DATA_W-1] && (cap_input_q != '0);
  assign error_nz  = (cap_error_q != '0);
  assign error_pos = !cap_error_q[DATA_W-1];
  assign learn_hit = cap_learn_q && !bus.learn_freeze && input_pos && error_nz;
  assign w_upd     = sat_add16(w_cur, error_pos ? LR_POS : LR_NEG, W_LO, W_HI);

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cap_id_d     = cap_id_q;
    cap_neuron_d = cap_neuron_q;
    cap_input_d  = cap_input_q;
    cap_error_d  = cap_error_q;
    cap_learn_d  = cap_learn_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    rsp_neuron_d = rsp_neuron_q;
    weight_d     = weight_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cap_id_d     = grant_idx;
          cap_neuron_d = win_neuron;
          cap_input_d  = win_input;
          cap_error_d  = win_error;
          cap_learn_d  = bus.req_learn[grant_idx];
          ptr_d        = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d   = product;
        rsp_id_d     = cap_id_q;
        rsp_neuron_d = cap_neuron_q;
        rsp_valid_d  = 1'b1;
        if (learn_hit) begin
          weight_d[cap_neuron_q] = w_upd;
        end
        state_d      = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cap_id_q     <= '0;
      cap_neuron_q <= '0;
      cap_input_q  <= '0;
      cap_error_q  <= '0;
      cap_learn_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      rsp_neuron_q <= '0;
      for (int i = 0; i < NUM_NEUR; i++) begin
        weight_q[i] <= W_INIT;
      end
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cap_id_q     <= cap_id_d;
      cap_neuron_q <= cap_neuron_d;
      cap_input_q  <= cap_input_d;
      cap_error_q  <= cap_error_d;
      cap_learn_q  <= cap_learn_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_neuron_q <= rsp_neuron_d;
      weight_q     <= weight_d;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_req_id = rsp_id_q;
  assign bus.rsp_neuron = rsp_neuron_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_plastic_neuron_scheduler.sv
// -----------------------------------------------------------------------------
// tb_plastic_neuron_scheduler
// Bench for plastic_neuron_scheduler: a default instance checked every cycle
// against a transaction-level model, plus a second instance with W_MAX=1005
// that mirrors the same stimulus for the weight-clamp case.
// -----------------------------------------------------------------------------
module tb_plastic_neuron_scheduler;
  import plastic_pkg::*;

  localparam int N  = 4;
  localparam int NW = 3;
  localparam int NN = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  plastic_neuron_scheduler_if #(.NUM_REQ(N), .NEUR_W(NW)) bus ();
  plastic_neuron_scheduler_if #(.NUM_REQ(N), .NEUR_W(NW)) bus_sat ();

  assign bus_sat.req_valid    = bus.req_valid;
  assign bus_sat.req_neuron   = bus.req_neuron;
  assign bus_sat.req_input    = bus.req_input;
  assign bus_sat.req_error    = bus.req_error;
  assign bus_sat.req_learn    = bus.req_learn;
  assign bus_sat.learn_freeze = bus.learn_freeze;
  assign bus_sat.rsp_ready    = bus.rsp_ready;

  plastic_neuron_scheduler #(.NUM_REQ(N), .NEUR_W(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  plastic_neuron_scheduler #(
    .NUM_REQ(N), .NEUR_W(NW), .LEARNING_RATE(10), .INIT_WEIGHT(1000),
    .W_MAX(1005), .W_MIN(-32768)
  ) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_sat)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(string name, longint got, longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  // ---------------- transaction-level reference model ----------------
  // m_phase: 0 free, 1 computing (edge after accept), 2 response offered.
  int         m_w [NN];
  int         m_ptr, m_phase, m_id, m_n, m_in, m_err, m_data;
  bit         m_learn;
  logic [N-1:0] exp_ready;
  int         win;

  function automatic int rr_pick(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic int clamp16(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NN; i++) m_w[i] = 1000;
      m_ptr   = 0;
      m_phase = 0;
    end
    exp_ready = '0;
    win = rr_pick(bus.req_valid, m_ptr);
    if (m_phase == 0 && win >= 0) exp_ready[win] = 1'b1;
    check("req_ready", bus.req_ready, exp_ready);
    check("busy", bus.busy, (m_phase != 0) ? 1 : 0);
    check("rsp_valid", bus.rsp_valid, (m_phase == 2) ? 1 : 0);
    if (m_phase == 2) begin
      check("rsp_data", $signed(bus.rsp_data), m_data);
      check("rsp_req_id", bus.rsp_req_id, m_id);
      check("rsp_neuron", bus.rsp_neuron, m_n);
    end
    if (!rst) begin
      case (m_phase)
        0: if (win >= 0) begin
          m_id    = win;
          m_n     = int'(bus.req_neuron[win*NW +: NW]);
          m_in    = $signed(bus.req_input[win*16 +: 16]);
          m_err   = $signed(bus.req_error[win*16 +: 16]);
          m_learn = bus.req_learn[win];
          m_ptr   = (win + 1) % N;
          m_phase = 1;
        end
        1: begin
          m_data = m_in * m_w[m_n];
          if (m_learn && !bus.learn_freeze && m_in > 0 && m_err != 0)
            m_w[m_n] = clamp16(m_w[m_n] + ((m_err > 0) ? 10 : -10));
          m_phase = 2;
        end
        default: if (bus.rsp_ready) m_phase = 0;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int id, input int n, input int in_v,
                         input int err, input bit learn);
    bus.req_valid[id]          = 1'b1;
    bus.req_neuron[id*NW +: NW] = NW'(n);
    bus.req_input[id*16 +: 16]  = 16'(in_v);
    bus.req_error[id*16 +: 16]  = 16'(err);
    bus.req_learn[id]          = learn;
  endtask

  task automatic rand_fields(input int id);
    int in_v;
    in_v = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                       : int'($urandom_range(0, 40)) - 20;
    set_req(id, $urandom_range(0, NN - 1), in_v,
            int'($urandom_range(0, 6)) - 3, 1'($urandom_range(0, 1)));
  endtask

  // Returns at accept-edge + 1 time unit.
  task automatic wait_accept(input int id);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 30 && !ok; c++) begin
      @(negedge clk);
      if (bus.req_ready[id]) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    check("accept_seen", ok, 1);
  endtask

  // Counts edges since the accept edge until rsp_valid is seen.
  task automatic wait_rsp(output int lat);
    bit ok;
    ok  = 1'b0;
    lat = 1;
    for (int c = 0; c < 30 && !ok; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    check("rsp_seen", ok, 1);
  endtask

  task automatic single(input int id, input int n, input int in_v, input int err,
                        input bit learn, input int exp_data, output int sat_data);
    int lat;
    set_req(id, n, in_v, err, learn);
    wait_accept(id);
    bus.req_valid[id] = 1'b0;
    wait_rsp(lat);
    check("latency", lat, 2);
    check("single_data", $signed(bus.rsp_data), exp_data);
    check("single_id", bus.rsp_req_id, id);
    check("single_neuron", bus.rsp_neuron, n);
    sat_data = $signed(bus_sat.rsp_data);
    @(posedge clk);
    #1;
  endtask

  task automatic rr_check(input int cnt, input int exp_a[6]);
    int got, idx;
    got = 0;
    for (int c = 0; c < 80 && got < cnt; c++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        check("rr_onehot", $countones(bus.req_ready), 1);
        idx = 0;
        for (int i = 0; i < N; i++) if (bus.req_ready[i]) idx = i;
        check("rr_order", idx, exp_a[got]);
        got++;
      end
    end
    check("rr_count", got, cnt);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int sd, lat;
    int ord [6];
    logic [31:0] snap;

    bus.req_valid    = '0;
    bus.req_neuron   = '0;
    bus.req_input    = '0;
    bus.req_error    = '0;
    bus.req_learn    = '0;
    bus.learn_freeze = 1'b0;
    bus.rsp_ready    = 1'b1;

    @(negedge clk);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_id", bus.rsp_req_id, 0);
    check("rst_rsp_neuron", bus.rsp_neuron, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_req_ready", bus.req_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Learning directions, non-positive input, zero error, freeze.
    single(0, 2, 3, 5, 1, 3000, sd);
    single(0, 2, 3, 5, 1, 3030, sd);
    single(0, 1, 4, -1, 1, 4000, sd);
    single(0, 1, 4, -1, 1, 3960, sd);
    single(1, 3, -2, 7, 1, -2000, sd);
    single(1, 3, -2, 7, 1, -2000, sd);
    single(3, 5, 6, 0, 1, 6000, sd);
    single(3, 5, 6, 0, 1, 6000, sd);
    bus.learn_freeze = 1'b1;
    single(2, 4, 5, 5, 1, 5000, sd);
    single(2, 4, 5, 5, 1, 5000, sd);
    bus.learn_freeze = 1'b0;

    // Round-robin with all requesters held valid.
    pulse_reset();
    for (int i = 0; i < N; i++) rand_fields(i);
    ord = '{0, 1, 2, 3, 0, 1};
    rr_check(6, ord);
    @(posedge clk);
    #1 rst = 1'b1;
    bus.req_valid[1] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    ord = '{0, 2, 3, 0, 0, 0};
    rr_check(4, ord);
    @(posedge clk);
    #1 bus.req_valid = '0;
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: response held, no accepts, accept right after release.
    bus.rsp_ready = 1'b0;
    set_req(3, 5, 7, 0, 0);
    wait_accept(3);
    bus.req_valid[3] = 1'b0;
    set_req(0, 6, 1, 0, 0);
    wait_rsp(lat);
    snap = bus.rsp_data;
    check("bp_id", bus.rsp_req_id, 3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", bus.rsp_valid, 1);
      check("bp_data", bus.rsp_data, snap);
      check("bp_id_hold", bus.rsp_req_id, 3);
      check("bp_no_ready", bus.req_ready, 0);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_before", bus.req_ready, 0);
    @(negedge clk);
    check("bp_accept_after", bus.req_ready, 1);
    @(posedge clk);
    #1 bus.req_valid = '0;
    repeat (4) @(posedge clk);
    #1;

    // Randomised traffic, checked by the model every cycle.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) rand_fields(i);
      bus.req_valid    = N'($urandom);
      bus.rsp_ready    = ($urandom_range(0, 3) != 0);
      bus.learn_freeze = ($urandom_range(0, 7) == 0);
    end
    @(posedge clk);
    #1;
    bus.req_valid    = '0;
    bus.rsp_ready    = 1'b1;
    bus.learn_freeze = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Reset in EXEC after a learning request.
    set_req(1, 0, 2, 3, 1);
    wait_accept(1);
    bus.req_valid[1] = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    check("midexec_rsp_valid", bus.rsp_valid, 0);
    check("midexec_busy", bus.busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < NN; k++) single(0, k, 2, 0, 0, 2000, sd);

    // Saturation: default instance keeps climbing, clamped one stops at 1005.
    single(0, 0, 1, 1, 1, 1000, sd);
    check("sat_first", sd, 1000);
    single(0, 0, 1, 1, 1, 1010, sd);
    check("sat_clamped", sd, 1005);
    single(0, 0, 1, 1, 1, 1020, sd);
    check("sat_held", sd, 1005);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/plastic_neuron_scheduler.md
Name: plastic_neuron_scheduler

Overview:
- Time-multiplexes one shared plastic-neuron datapath (signed 16x16 multiply plus Hebbian weight update) across NUM_REQ requesters.
- Holds a bank of 2**NEUR_W virtual-neuron weights.
- Arbitrates requests round-robin, runs inference with an optional learning update, and returns a tagged 32-bit result over a valid/ready response channel.
- Sits between the spike/feature front-ends and the downstream accumulator.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- NEUR_W, 3: neuron index width; the weight bank holds 2**NEUR_W entries.
- LEARNING_RATE, 10: signed 16-bit weight step.
- INIT_WEIGHT, 1000: reset value of every weight.
- W_MAX, 32767: upper saturation bound for a weight (signed 16-bit).
- W_MIN, -32768: lower saturation bound for a weight (signed 16-bit).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_neuron  in  NUM_REQ*NEUR_W  flattened target neuron index; requester i uses slice i.
- req_input  in  NUM_REQ*16  flattened signed input.
- req_error  in  NUM_REQ*16  flattened signed feedback error.
- req_learn  in  NUM_REQ  per-request plasticity enable.
- learn_freeze  in  1  global learning inhibit; sampled in EXEC.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_data  out  32  signed product input*weight.
- rsp_req_id  out  clog2(NUM_REQ)  index of the requester served.
- rsp_neuron  out  NEUR_W  index of the neuron used.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values:
  - State IDLE.
  - All weights = INIT_WEIGHT.
  - Round-robin pointer = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_req_id = 0, rsp_neuron = 0, busy = 0.
  - req_ready = 0.
- FSM has three states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - req_ready is combinational and only asserted in IDLE: one-hot on the round-robin winner among asserted req_valid bits.
  - The search starts at the pointer and wraps modulo NUM_REQ.
  - On the handshake, capture the winner's neuron, input, error, learn and id; set pointer = winner+1 (wrapping); go to EXEC.
  - If no req_valid is asserted, stay in IDLE and leave the pointer unchanged.
- EXEC (1 cycle):
  - Read weight w[n] and register rsp_data = signed(input)*signed(w[n]) as a full 32-bit product using the pre-update weight.
  - Register rsp_req_id and rsp_neuron.
  - Apply the learning update if learn=1 and learn_freeze=0:
    - input>0 and error>0: w[n] = min(w+LEARNING_RATE, W_MAX).
    - input>0 and error<0: w[n] = max(w-LEARNING_RATE, W_MIN).
    - Otherwise (input<=0 or error==0): no change.
  - Compute the add/subtract at 17 bits, then saturate; a weight never wraps.
  - Go to RESP.
- RESP:
  - rsp_valid = 1.
  - rsp_data, rsp_req_id and rsp_neuron stay stable until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid = 0 and go to IDLE.
  - No request is accepted while in EXEC or RESP.
- Latency and throughput:
  - Accept edge at cycle N; rsp_valid is high from cycle N+2.
  - Peak throughput is 1 request per 3 cycles when rsp_ready is held high.
- Back-to-back requests to the same neuron see the updated weight, because the update commits in EXEC before the next accept.
- Request inputs are sampled only on the accept edge; changes afterwards have no effect.
- Reset asserted mid-operation (any state): immediate return to reset values, all weights re-initialised, any in-flight response discarded.
- Only one requester is served at a time, so the weight bank never sees concurrent writes.

Decomposition:
- Shared package plastic_pkg holds the constants and types reused by the neuron blocks:
  - Constants DATA_W=16, PROD_W=32.
  - Default LEARNING_RATE and INIT_WEIGHT.
  - Enum sched_state_t {IDLE, EXEC, RESP}.
  - Function sat_add16 (saturating signed add with bounds).
- One sub-module: rr_arbiter (parameter N). Inputs: req vector and pointer. Outputs: one-hot grant and encoded grant index. Purely combinational; the pointer register lives in the scheduler.

Test Plan:
- Reset check, single request: requester 0, neuron 2, input 3, error 5, learn 1.
  - Expect rsp_valid 2 cycles after accept with rsp_data=3000, rsp_req_id=0, rsp_neuron=2.
  - Expect w[2]=1010.
  - Repeat the same request: expect rsp_data=3030.
- Negative error and non-positive input:
  - input 4, error -1, learn 1 on neuron 1: expect 4000, then 3960 on the repeat.
  - input -2, error 7: expect -2000 and weight unchanged.
  - With learn_freeze=1: weight unchanged.
- Saturation: W_MAX=1005 and LEARNING_RATE=10; input 1, error 1, learn on neuron 0.
  - Expect the weight to clamp at 1005.
  - The following response returns 1005.
- Round-robin fairness: all 4 requesters held valid, rsp_ready tied to 1.
  - Expect grant order 0,1,2,3,0,1 and exactly one req_ready bit per accept.
  - Drop requester 1 to leave 0,2,3 valid: expect order 0,2,3,0.
- Backpressure: hold rsp_ready=0 for 5 cycles during RESP.
  - Expect rsp_valid, rsp_data and rsp_req_id stable.
  - Expect req_ready=0 throughout.
  - Expect the accept to occur the cycle after rsp_ready rises.
- Reset mid-EXEC after a learning request:
  - Expect rsp_valid=0.
  - Expect every weight back at 1000.
  - Expect the next single request with input 2 to return 2000 from requester 0.
